// File: rtl/recov_sched.sv
// Check-node message recovery sequencer: captures a row's compressed min-sum
// state and streams DEG recovered two's-complement messages in column order.

module recov_lane #(
  parameter int W   = 10,
  parameter int IW  = 3,
  parameter int COL = 0
) (
  input  logic [W-2:0]  min1,
  input  logic [W-2:0]  min2,
  input  logic [IW-1:0] min1_idx,
  input  logic          sgn,
  output logic [W-1:0]  msg
);
  localparam logic [IW-1:0] CIDX = IW'(COL);

  logic [W-1:0] x;

  // min1_idx >= DEG can never equal CIDX, so such rows fall back to min1 everywhere
  assign x   = {1'b0, (min1_idx == CIDX) ? min2 : min1};
  assign msg = sgn ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;
endmodule

module recov_sched #(
  parameter int W   = 10,
  parameter int DEG = 8,
  parameter int IW  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-2:0]   min1,
  input  logic [W-2:0]   min2,
  input  logic [IW-1:0]  min1_idx,
  input  logic           sgn_prod,
  input  logic [DEG-1:0] edge_sgn,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_msg,
  output logic [IW-1:0]  out_col,
  output logic           done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [W-2:0]   c_min1, c_min2;
  logic [IW-1:0]  c_idx;
  logic           c_sp;
  logic [DEG-1:0] c_es;
  logic [IW-1:0]  col;
  logic [W-1:0]   msg_r;
  logic [IW-1:0]  col_r;

  logic [W-2:0]   s_min1, s_min2;
  logic [IW-1:0]  s_idx;
  logic           s_sp;
  logic [DEG-1:0] s_es;

  logic [DEG-1:0][W-1:0] msgs;
  logic [IW-1:0]         sel;
  logic [W-1:0]          nxt_msg;
  logic                  hs, last;

  // In IDLE the lanes see the live inputs so column 0 is ready on the capture edge
  assign s_min1 = (state == S_IDLE) ? min1     : c_min1;
  assign s_min2 = (state == S_IDLE) ? min2     : c_min2;
  assign s_idx  = (state == S_IDLE) ? min1_idx : c_idx;
  assign s_sp   = (state == S_IDLE) ? sgn_prod : c_sp;
  assign s_es   = (state == S_IDLE) ? edge_sgn : c_es;

  genvar g;
  generate
    for (g = 0; g < DEG; g++) begin : g_lane
      recov_lane #(.W(W), .IW(IW), .COL(g)) u_lane (
        .min1     (s_min1),
        .min2     (s_min2),
        .min1_idx (s_idx),
        .sgn      (s_sp ^ s_es[g]),
        .msg      (msgs[g])
      );
    end
  endgenerate

  assign sel  = (state == S_IDLE) ? '0 : col + IW'(1);
  assign hs   = (state == S_RUN) && out_ready;
  assign last = (col == IW'(DEG-1));

  always_comb begin
    nxt_msg = '0;
    for (int c = 0; c < DEG; c++)
      if (sel == IW'(c)) nxt_msg = msgs[c];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (hs && last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_min1 <= '0;
      c_min2 <= '0;
      c_idx  <= '0;
      c_sp   <= 1'b0;
      c_es   <= '0;
      col    <= '0;
      msg_r  <= '0;
      col_r  <= '0;
    end else if (state == S_IDLE && start) begin
      c_min1 <= min1;
      c_min2 <= min2;
      c_idx  <= min1_idx;
      c_sp   <= sgn_prod;
      c_es   <= edge_sgn;
      col    <= '0;
      msg_r  <= nxt_msg;
      col_r  <= '0;
    end else if (hs) begin
      if (last) begin
        col   <= '0;
        msg_r <= '0;
        col_r <= '0;
      end else begin
        col   <= col + IW'(1);
        msg_r <= nxt_msg;
        col_r <= col + IW'(1);
      end
    end
  end

  assign busy      = (state == S_RUN);
  assign out_valid = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign out_msg   = msg_r;
  assign out_col   = col_r;
endmodule

// File: tb/tb_recov_sched.sv
// Scoreboard bench for recov_sched: DEG=8 main instance plus a DEG=6 instance
// for the out-of-range min1_idx case.

module tb_recov_sched;
  logic       clk = 1'b0;
  logic       rst, start, start6, out_ready, sgn_prod;
  logic [8:0] min1, min2;
  logic [2:0] min1_idx;
  logic [7:0] edge_sgn;
  logic       busy, out_valid, done;
  logic [9:0] out_msg;
  logic [2:0] out_col;
  logic       busy6, out_valid6, done6;
  logic [9:0] out_msg6;
  logic [2:0] out_col6;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] col;
    logic [9:0] msg;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  recov_sched #(.W(10), .DEG(8), .IW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .min1(min1), .min2(min2),
    .min1_idx(min1_idx), .sgn_prod(sgn_prod), .edge_sgn(edge_sgn),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_msg(out_msg), .out_col(out_col), .done(done)
  );

  recov_sched #(.W(10), .DEG(6), .IW(3)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .min1(min1), .min2(min2),
    .min1_idx(min1_idx), .sgn_prod(sgn_prod), .edge_sgn(edge_sgn[5:0]),
    .busy(busy6), .out_valid(out_valid6), .out_ready(out_ready),
    .out_msg(out_msg6), .out_col(out_col6), .done(done6)
  );

  function automatic logic [9:0] model(input logic [8:0] m1, input logic [8:0] m2,
                                       input logic [2:0] idx, input logic sp,
                                       input logic [7:0] es, input int c);
    logic [8:0] mag;
    logic [9:0] x;
    mag = (int'(idx) == c) ? m2 : m1;
    x   = {1'b0, mag};
    return (sp ^ es[c]) ? 10'(10'd0 - x) : x;
  endfunction

  // Drives one DEG=8 row; rmode 0 = always ready, 1 = ready pattern 1,0,0,...
  task automatic run_row(input logic [8:0] m1, input logic [8:0] m2, input logic [2:0] idx,
                         input logic sp, input logic [7:0] es, input int rmode,
                         input bit busy_start, output int nhs, output int first_v,
                         output int done_k);
    exp_t e;
    bit stalled, did;
    logic [9:0] pmsg;
    logic [2:0] pcol;
    sbq.delete();
    for (int c = 0; c < 8; c++) begin
      e.col = 3'(c);
      e.msg = model(m1, m2, idx, sp, es, c);
      sbq.push_back(e);
    end
    nhs = 0; first_v = -1; done_k = -1; stalled = 0; did = 0; pmsg = '0; pcol = '0;
    @(negedge clk);
    min1 = m1; min2 = m2; min1_idx = idx; sgn_prod = sp; edge_sgn = es;
    start = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      min1  = m1;
      if (done) begin
        done_k = k;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL done_cycle busy=%b valid=%b want 0 0", busy, out_valid);
        end
        if (busy_start) start = 1'b1;
        break;
      end
      checks++;
      if (busy !== out_valid) begin
        errors++;
        $display("FAIL busy_vs_valid busy=%b valid=%b k=%0d", busy, out_valid, k);
      end
      if (out_valid && first_v < 0) first_v = k;
      if (stalled) begin
        checks++;
        if (out_msg !== pmsg || out_col !== pcol) begin
          errors++;
          $display("FAIL stall_hold msg=%h col=%0d want %h %0d", out_msg, out_col, pmsg, pcol);
        end
      end
      if (busy_start && out_valid && out_col == 3'd3 && !did) begin
        start = 1'b1;
        min1  = 9'd99;
        did   = 1;
      end
      out_ready = (rmode == 0) ? 1'b1 : (((k - 1) % 3) == 0);
      if (out_valid && out_ready) begin
        stalled = 0;
        nhs++;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL extra_handshake col=%0d msg=%h want none", out_col, out_msg);
        end else begin
          e = sbq.pop_front();
          if (out_msg !== e.msg || out_col !== e.col) begin
            errors++;
            $display("FAIL row_word col=%0d msg=%h want col=%0d msg=%h",
                     out_col, out_msg, e.col, e.msg);
          end
        end
      end else if (out_valid) begin
        stalled = 1; pmsg = out_msg; pcol = out_col;
      end else begin
        stalled = 0;
      end
    end
    out_ready = 1'b1;
    checks++;
    if (done_k < 0) begin
      errors++;
      $display("FAIL row_timeout done not seen within 200 cycles want done");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start6 = 1'b0; out_ready = 1'b1;
    min1 = '0; min2 = '0; min1_idx = '0; sgn_prod = 1'b0; edge_sgn = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, out_valid, out_msg, out_col, done} !== '0 ||
        {busy6, out_valid6, out_msg6, out_col6, done6} !== '0) begin
      errors++;
      $display("FAIL reset_outputs dut=%b_%b_%h_%0d_%b dut6=%b_%b_%h_%0d_%b want all 0",
               busy, out_valid, out_msg, out_col, done,
               busy6, out_valid6, out_msg6, out_col6, done6);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int nhs, fv, dk;
    run_row(9'd5, 9'd12, 3'd2, 1'b1, 8'b00000101, 0, 0, nhs, fv, dk);
    checks++;
    if (nhs != 8 || fv != 1 || dk != 9) begin
      errors++;
      $display("FAIL basic_timing hs=%0d first=%0d done=%0d want 8 1 9", nhs, fv, dk);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_after done=%b valid=%b busy=%b want 0 0 0", done, out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    int nhs, fv, dk;
    run_row(9'd5, 9'd12, 3'd2, 1'b1, 8'b00000101, 1, 0, nhs, fv, dk);
    checks++;
    if (nhs != 8 || dk != 23) begin
      errors++;
      $display("FAIL bp_count hs=%0d done=%0d want 8 23", nhs, dk);
    end
  endtask

  task automatic test_boundaries();
    int nhs, fv, dk;
    run_row(9'd0, 9'd0, 3'd0, 1'b0, 8'hFF, 0, 0, nhs, fv, dk);
    checks++;
    if (nhs != 8) begin
      errors++;
      $display("FAIL zero_row hs=%0d want 8", nhs);
    end
    run_row(9'd511, 9'd511, 3'd0, 1'b1, 8'h00, 0, 0, nhs, fv, dk);
    checks++;
    if (nhs != 8) begin
      errors++;
      $display("FAIL max_row hs=%0d want 8", nhs);
    end
  endtask

  task automatic test_idx_range();
    int nhs, fv, dk, cnt;
    exp_t e;
    run_row(9'd20, 9'd33, 3'd7, 1'b0, 8'b10010010, 0, 0, nhs, fv, dk);
    checks++;
    if (nhs != 8) begin
      errors++;
      $display("FAIL idx7_row hs=%0d want 8", nhs);
    end
    sbq.delete();
    for (int c = 0; c < 6; c++) begin
      e.col = 3'(c);
      e.msg = model(9'd7, 9'd3, 3'd7, 1'b0, 8'h2A, c);
      sbq.push_back(e);
    end
    @(negedge clk);
    min1 = 9'd7; min2 = 9'd3; min1_idx = 3'd7; sgn_prod = 1'b0; edge_sgn = 8'h2A;
    start6 = 1'b1; out_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start6 = 1'b0;
      if (done6) break;
      if (out_valid6) begin
        cnt++;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL deg6_extra col=%0d msg=%h want none", out_col6, out_msg6);
        end else begin
          e = sbq.pop_front();
          if (out_msg6 !== e.msg || out_col6 !== e.col) begin
            errors++;
            $display("FAIL deg6_word col=%0d msg=%h want col=%0d msg=%h",
                     out_col6, out_msg6, e.col, e.msg);
          end
        end
      end
    end
    checks++;
    if (cnt != 6 || done6 !== 1'b1) begin
      errors++;
      $display("FAIL deg6_count words=%0d done=%b want 6 1", cnt, done6);
    end
  endtask

  task automatic test_start_busy();
    int nhs, fv, dk;
    run_row(9'd5, 9'd12, 3'd2, 1'b1, 8'b00000101, 0, 1, nhs, fv, dk);
    checks++;
    if (nhs != 8 || dk != 9) begin
      errors++;
      $display("FAIL busy_start_row hs=%0d done=%0d want 8 9", nhs, dk);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_on_done busy=%b valid=%b want 0 0", busy, out_valid);
    end
    run_row(9'd40, 9'd50, 3'd5, 1'b0, 8'b01100001, 0, 0, nhs, fv, dk);
    checks++;
    if (nhs != 8 || fv != 1) begin
      errors++;
      $display("FAIL start_in_idle hs=%0d first=%0d want 8 1", nhs, fv);
    end
  endtask

  task automatic test_reset_mid();
    int nhs, fv, dk, ndone;
    bit hit;
    @(negedge clk);
    min1 = 9'd5; min2 = 9'd12; min1_idx = 3'd2; sgn_prod = 1'b1; edge_sgn = 8'b00000101;
    start = 1'b1; out_ready = 1'b1;
    hit = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_col == 3'd4) begin
        hit = 1;
        break;
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (!hit || {busy, out_valid, out_msg, out_col, done} !== '0) begin
      errors++;
      $display("FAIL reset_mid hit=%b outs=%b_%b_%h_%0d_%b want 1 and all 0",
               hit, busy, out_valid, out_msg, out_col, done);
    end
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || out_valid) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet activity=%0d want 0", ndone);
    end
    run_row(9'd5, 9'd12, 3'd2, 1'b1, 8'b00000101, 0, 0, nhs, fv, dk);
    checks++;
    if (nhs != 8 || fv != 1 || dk != 9) begin
      errors++;
      $display("FAIL reset_mid_restart hs=%0d first=%0d done=%0d want 8 1 9", nhs, fv, dk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_boundaries();
    test_idx_range();
    test_start_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
